// File: rtl/dcache_nway_pkg.sv
// Shared field-width helpers and controller states for the N-way write-back data cache.
package dcache_nway_pkg;

   typedef enum logic [2:0] {IDLE, WB, FILL, SCAN, FLUSH_WB, HITCNT, HALTED} state_t;

   // Width of an address field covering n entries; 0 when the field is absent.
   function automatic int fld_w(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   // Width of a register indexing n entries; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int tag_w(input int sets, input int blkwords);
      return 30 - fld_w(sets) - fld_w(blkwords);
   endfunction

endpackage

// File: rtl/dcache_nway_lru_ages.sv
// True-LRU age update for one set: 0 is most recent, WAYS-1 is the replacement candidate.
module lru_ages
   import dcache_nway_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int AW   = ptr_w(WAYS)
) (
   input  logic [WAYS-1:0][AW-1:0] ages,
   input  logic [AW-1:0]           touch,
   output logic [WAYS-1:0][AW-1:0] next_ages,
   output logic [AW-1:0]           victim
);

   logic [AW-1:0] old_age;

   always_comb begin
      old_age = ages[touch];
      victim  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (AW'(w) == touch)
            next_ages[w] = '0;
         else if (ages[w] < old_age)
            next_ages[w] = ages[w] + AW'(1);
         else
            next_ages[w] = ages[w];
         if (ages[w] == AW'(WAYS - 1))
            victim = AW'(w);
      end
   end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement
// and a halt-triggered flush that ends by writing the hit count to HITCNT_ADDR.
module dcache_nway
   import dcache_nway_pkg::*;
#(
   parameter int          WAYS        = 2,
   parameter int          SETS        = 8,
   parameter int          BLKWORDS    = 2,
   parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic [31:0] dload,
   input  logic        dwait
);

   localparam int OB   = fld_w(BLKWORDS);
   localparam int TAGW = tag_w(SETS, BLKWORDS);
   localparam int OW   = ptr_w(BLKWORDS);
   localparam int WW   = ptr_w(WAYS);
   localparam int SW   = ptr_w(SETS);
   localparam logic [OW-1:0] LAST_WORD = OW'(BLKWORDS - 1);
   localparam logic [WW-1:0] LAST_WAY  = WW'(WAYS - 1);
   localparam logic [SW-1:0] LAST_SET  = SW'(SETS - 1);

   logic [WAYS-1:0]         valid [SETS];
   logic [WAYS-1:0]         dirty [SETS];
   logic [WAYS-1:0][WW-1:0] ages  [SETS];
   logic [TAGW-1:0]         tags  [SETS][WAYS];
   logic [31:0]             data  [SETS][WAYS][BLKWORDS];

   state_t          state;
   logic [OW-1:0]   wcnt;
   logic [SW-1:0]   sptr;
   logic [WW-1:0]   wptr, vic;
   logic [31:0]     hit_cnt;
   logic            replay;

   logic [29:0]     waddr;
   logic            unused_byte;
   logic [OW-1:0]   blkoff;
   logic [SW-1:0]   idx;
   logic [TAGW-1:0] req_tag;

   assign waddr       = dmemaddr[31:2];
   assign unused_byte = ^dmemaddr[1:0];
   assign idx         = waddr[OB +: SW];
   assign req_tag     = waddr[OB + SW +: TAGW];

   generate
      if (OB == 0) begin : g_one_word
         assign blkoff = '0;
      end else begin : g_multi_word
         assign blkoff = waddr[OW-1:0];
      end
   endgenerate

   function automatic logic [31:0] blk_addr(input logic [TAGW-1:0] t, input logic [SW-1:0] s,
                                            input logic [OW-1:0] w);
      return (32'({t, s, 2'b00}) << OB) | (32'(w) << 2);
   endfunction

   logic                    req, is_store, hit, idle_hit, store_hit, fill_we, last_word, last_line;
   logic [WW-1:0]           hit_way, victim, lru_victim, touch, wptr_nxt;
   logic [SW-1:0]           sptr_nxt;
   logic [WAYS-1:0][WW-1:0] age_eff, next_ages;

   assign req       = dmemREN | dmemWEN;
   assign is_store  = dmemWEN & ~dmemREN;
   assign idle_hit  = (state == IDLE) && req && hit;
   assign store_hit = idle_hit && is_store;
   assign fill_we   = (state == FILL) && !dwait;
   assign last_word = (wcnt == LAST_WORD);
   assign last_line = (sptr == LAST_SET) && (wptr == LAST_WAY);
   assign wptr_nxt  = (wptr == LAST_WAY) ? '0 : wptr + WW'(1);
   assign sptr_nxt  = (wptr == LAST_WAY) ? sptr + SW'(1) : sptr;
   assign touch     = (state == FILL) ? vic : hit_way;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = lru_victim;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[idx][w] && tags[idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
         // Invalid ways look oldest, so filling one ages every valid way and the
         // valid ways always hold distinct ages once the set is full.
         age_eff[w] = valid[idx][w] ? ages[idx][w] : LAST_WAY;
      end
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[idx][w])
            victim = WW'(w);
   end

   lru_ages #(.WAYS(WAYS), .AW(WW)) u_lru (
      .ages      (age_eff),
      .touch     (touch),
      .next_ages (next_ages),
      .victim    (lru_victim)
   );

   always_ff @(posedge CLK) begin
      if (store_hit)
         data[idx][hit_way][blkoff] <= dmemstore;
      else if (fill_we)
         data[idx][vic][wcnt] <= dload;
      if (fill_we && last_word)
         tags[idx][vic] <= req_tag;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         wcnt    <= '0;
         sptr    <= '0;
         wptr    <= '0;
         vic     <= '0;
         hit_cnt <= '0;
         replay  <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            ages[s]  <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               replay <= 1'b0;
               if (req) begin
                  if (hit) begin
                     if (!replay)
                        hit_cnt <= hit_cnt + 32'd1;
                     if (is_store)
                        dirty[idx][hit_way] <= 1'b1;
                     ages[idx] <= next_ages;
                  end else begin
                     vic   <= victim;
                     wcnt  <= '0;
                     state <= (valid[idx][victim] && dirty[idx][victim]) ? WB : FILL;
                  end
               end else if (halt) begin
                  sptr  <= '0;
                  wptr  <= '0;
                  state <= SCAN;
               end
            end
            WB: if (!dwait) begin
               if (last_word) begin
                  wcnt             <= '0;
                  dirty[idx][vic]  <= 1'b0;
                  state            <= FILL;
               end else
                  wcnt <= wcnt + OW'(1);
            end
            FILL: if (!dwait) begin
               if (last_word) begin
                  wcnt            <= '0;
                  valid[idx][vic] <= 1'b1;
                  dirty[idx][vic] <= 1'b0;
                  ages[idx]       <= next_ages;
                  replay          <= 1'b1;
                  state           <= IDLE;
               end else
                  wcnt <= wcnt + OW'(1);
            end
            SCAN: begin
               if (valid[sptr][wptr] && dirty[sptr][wptr]) begin
                  wcnt  <= '0;
                  state <= FLUSH_WB;
               end else begin
                  sptr <= sptr_nxt;
                  wptr <= wptr_nxt;
                  if (last_line)
                     state <= HITCNT;
               end
            end
            FLUSH_WB: if (!dwait) begin
               if (last_word) begin
                  wcnt              <= '0;
                  dirty[sptr][wptr] <= 1'b0;
                  sptr              <= sptr_nxt;
                  wptr              <= wptr_nxt;
                  state             <= last_line ? HITCNT : SCAN;
               end else
                  wcnt <= wcnt + OW'(1);
            end
            HITCNT: if (!dwait)
               state <= HALTED;
            default: ;
         endcase
      end
   end

   always_comb begin
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = '0;
      dstore = '0;
      case (state)
         WB: begin
            dWEN   = 1'b1;
            daddr  = blk_addr(tags[idx][vic], idx, wcnt);
            dstore = data[idx][vic][wcnt];
         end
         FILL: begin
            dREN  = 1'b1;
            daddr = blk_addr(req_tag, idx, wcnt);
         end
         FLUSH_WB: begin
            dWEN   = 1'b1;
            daddr  = blk_addr(tags[sptr][wptr], sptr, wcnt);
            dstore = data[sptr][wptr][wcnt];
         end
         HITCNT: begin
            dWEN   = 1'b1;
            daddr  = HITCNT_ADDR;
            dstore = hit_cnt;
         end
         default: ;
      endcase
   end

   assign dhit     = idle_hit;
   assign dmemload = (idle_hit && dmemREN) ? data[idx][hit_way][blkoff] : '0;
   assign flushed  = (state == HALTED);

endmodule

// File: tb/tb_dcache_nway.sv
// Directed scoreboard bench for dcache_nway (4 ways, 8 sets, 2-word blocks) with a
// stallable word-wide memory model.
module tb_dcache_nway;

   logic        CLK = 1'b0;
   logic        nRST, dmemREN, dmemWEN, halt;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit, flushed, dREN, dWEN, dwait;
   logic [31:0] dmemload, daddr, dstore, dload;

   always #5 CLK = ~CLK;

   dcache_nway #(.WAYS(4), .SETS(8), .BLKWORDS(2), .HITCNT_ADDR(32'h3100)) dut (
      .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
   );

   int          errors = 0;
   int          checks = 0;
   int          wait_cfg = 0;
   int          stall_cnt = 0;
   logic [31:0] wmem   [4096];
   bit          wvalid [4096];
   logic [31:0] shadow [4096];
   logic [63:0] act_wr [$];
   logic [31:0] act_rd [$];
   logic [31:0] exp_q  [$];

   function automatic logic [31:0] init_val(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Memory: unwritten words read back as init_val; each word stalls wait_cfg cycles.
   assign dwait = (wait_cfg != 0) && (dREN || dWEN) && (stall_cnt < wait_cfg);
   assign dload = !dREN ? 32'h0 :
                  wvalid[daddr[13:2]] ? wmem[daddr[13:2]] : init_val(int'(daddr[13:2]));

   always @(posedge CLK or negedge nRST) begin
      if (!nRST)
         stall_cnt <= 0;
      else if (dREN || dWEN) begin
         if (dwait)
            stall_cnt <= stall_cnt + 1;
         else begin
            stall_cnt <= 0;
            if (dWEN) begin
               wmem[daddr[13:2]]   <= dstore;
               wvalid[daddr[13:2]] <= 1'b1;
               act_wr.push_back({daddr, dstore});
            end else
               act_rd.push_back(daddr);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
      logic [63:0] e;
      e = '1;
      if (act_wr.size() != 0) e = act_wr.pop_front();
      check({tag, "_addr"}, e[63:32], a);
      check({tag, "_data"}, e[31:0], d);
   endtask

   task automatic expect_rd(input string tag, input logic [31:0] a);
      logic [31:0] e;
      e = '1;
      if (act_rd.size() != 0) e = act_rd.pop_front();
      check(tag, e, a);
   endtask

   // One request, held until dhit; checks latency, load data and address stability under stall.
   task automatic access(input string tag, input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat);
      int          n;
      logic        prev_stall;
      logic [31:0] prev_addr;
      if (ren) exp_q.push_back(shadow[addr[13:2]]);
      else if (wen) shadow[addr[13:2]] = wdata;
      dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = wdata;
      n = 0; prev_stall = 1'b0; prev_addr = '0;
      forever begin
         @(negedge CLK);
         if (prev_stall) check({tag, "_stall_addr"}, daddr, prev_addr);
         prev_stall = (dREN || dWEN) && dwait;
         prev_addr  = daddr;
         if (dhit || n > 200) break;
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      if (ren) check({tag, "_load"}, (dhit ? dmemload : 32'hDEAD_BEEF), exp_q.pop_front());
      @(posedge CLK); #1;
      dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dmemaddr = '0; dmemstore = '0;
      @(posedge CLK); @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dmemaddr = '0; dmemstore = '0;

      // Reset state
      @(negedge CLK);
      check("rst_dhit", 32'(dhit), 0);
      check("rst_dREN", 32'(dREN), 0);
      check("rst_dWEN", 32'(dWEN), 0);
      check("rst_daddr", daddr, 0);
      check("rst_dstore", dstore, 0);
      check("rst_dmemload", dmemload, 0);
      check("rst_flushed", 32'(flushed), 0);
      @(posedge CLK); #1 nRST = 1'b1;

      // Cold miss then same-block hit
      access("ld0", 1, 0, 32'h0000, 0, 3);
      expect_rd("fill0_w0", 32'h0000);
      expect_rd("fill0_w1", 32'h0004);
      access("ld4", 1, 0, 32'h0004, 0, 0);

      // Five-cycle stall on every fill word: ten cycles later than zero-wait
      wait_cfg = 5;
      access("ld8_stall", 1, 0, 32'h0008, 0, 13);
      wait_cfg = 0;
      expect_rd("fill8_w0", 32'h0008);
      expect_rd("fill8_w1", 32'h000C);

      // Dirty lines in sets 1 and 6; simultaneous REN/WEN behaves as a load
      access("st8", 0, 1, 32'h0008, 32'h1111_2222, 0);
      access("st30", 0, 1, 32'h0030, 32'h3333_4444, 3);
      expect_rd("fill30_w0", 32'h0030);
      expect_rd("fill30_w1", 32'h0034);
      access("both4", 1, 1, 32'h0004, 32'h9999_9999, 0);
      access("ld4_again", 1, 0, 32'h0004, 0, 0);
      check("no_wr_yet", 32'(act_wr.size()), 0);

      // Flush: 32 scan cycles, two 2-word writebacks, then the hit-count write
      halt = 1'b1;
      n = 0;
      forever begin
         @(negedge CLK);
         if (flushed || n > 500) break;
         n++;
      end
      check("flush_cycles", 32'(n), 38);
      expect_wr("fl_s1_w0", 32'h0008, 32'h1111_2222);
      expect_wr("fl_s1_w1", 32'h000C, init_val(3));
      expect_wr("fl_s6_w0", 32'h0030, 32'h3333_4444);
      expect_wr("fl_s6_w1", 32'h0034, init_val(13));
      expect_wr("hitcnt", 32'h3100, 32'd4);
      dmemREN = 1'b1; dmemaddr = 32'h0004;
      for (int i = 0; i < 3; i++) @(negedge CLK);
      check("flushed_held", 32'(flushed), 1);
      check("halted_no_hit", 32'(dhit), 0);
      check("halted_bus_idle", 32'({dREN, dWEN}), 0);
      check("halted_no_extra_wr", 32'(act_wr.size()), 0);

      // Dirty victim written back only on the fifth distinct tag in set 0
      do_reset();
      act_rd.delete();
      access("st100", 0, 1, 32'h0100, 32'hAAAA_5555, 3);
      access("ld140", 1, 0, 32'h0140, 0, 3);
      access("ld180", 1, 0, 32'h0180, 0, 3);
      access("ld1c0", 1, 0, 32'h01C0, 0, 3);
      check("no_early_wb", 32'(act_wr.size()), 0);
      act_rd.delete();
      access("ld200", 1, 0, 32'h0200, 0, 5);
      expect_wr("wb100_w0", 32'h0100, 32'hAAAA_5555);
      expect_wr("wb100_w1", 32'h0104, init_val(32'h41));
      expect_rd("fill200_w0", 32'h0200);
      expect_rd("fill200_w1", 32'h0204);
      access("ld100_back", 1, 0, 32'h0100, 0, 3);

      // LRU order in set 3: fill A..D, touch A, miss E evicts B
      access("lruA", 1, 0, 32'h0018, 0, 3);
      access("lruB", 1, 0, 32'h0058, 0, 3);
      access("lruC", 1, 0, 32'h0098, 0, 3);
      access("lruD", 1, 0, 32'h00D8, 0, 3);
      access("touchA", 1, 0, 32'h0018, 0, 0);
      access("missE", 1, 0, 32'h0118, 0, 3);
      access("hitA", 1, 0, 32'h0018, 0, 0);
      access("hitC", 1, 0, 32'h0098, 0, 0);
      access("hitD", 1, 0, 32'h00D8, 0, 0);
      access("hitE", 1, 0, 32'h0118, 0, 0);
      access("missB", 1, 0, 32'h0058, 0, 3);

      // Reset in the middle of a fill aborts it and leaves the line invalid
      dmemREN = 1'b1; dmemaddr = 32'h0028;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("midfill_dREN", 32'(dREN), 1);
      nRST = 1'b0;
      #1;
      check("abort_dREN", 32'(dREN), 0);
      check("abort_dWEN", 32'(dWEN), 0);
      check("abort_daddr", daddr, 0);
      check("abort_dhit", 32'(dhit), 0);
      dmemREN = 1'b0; dmemaddr = '0;
      @(posedge CLK); #1 nRST = 1'b1;
      access("ld28_after_abort", 1, 0, 32'h0028, 0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache that sits between the datapath's data port and the memory-side cache bus, and replaces the fixed 2-way/8-set/2-word design. Set count, associativity and block size are generic. Replacement is true-LRU by per-way age counters. On halt it flushes every dirty block, writes the hit count to a fixed address, then raises `flushed`.

## Interface
Parameters:
- `WAYS`, 2: associativity; power of two, 1..8.
- `SETS`, 8: sets; power of two, ≥2.
- `BLKWORDS`, 2: 32-bit words per block; power of two, ≥1.
- `HITCNT_ADDR`, 32'h3100: address written with the hit count at the end of a flush.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `dmemREN` in 1: datapath load request.
- `dmemWEN` in 1: datapath store request.
- `dmemaddr` in 32: word-aligned byte address.
- `dmemstore` in 32: store data.
- `halt` in 1: datapath halted; start flush.
- `dhit` out 1: request completes this cycle.
- `dmemload` out 32: load data; valid when `dhit`.
- `flushed` out 1: flush and hit-count write complete.
- `dREN` out 1: memory read request.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory address.
- `dstore` out 32: memory write data.
- `dload` in 32: memory read data.
- `dwait` in 1: memory busy; a word transfers on the cycle `dREN|dWEN` is high and `dwait` is low.

## Operation
- Address split, LSB first: byte offset [1:0] (ignored); blkoff log2(BLKWORDS) bits; idx log2(SETS) bits; tag = remaining bits.
- Per line: valid, dirty, tag, BLKWORDS data words. Per set: one log2(WAYS)-bit age per way; 0 = MRU.
- `dmemREN` and `dmemWEN` together are a protocol error; the block treats the pair as a load.
- Hit (IDLE): a valid way has a matching tag.
  - Load: drive `dmemload` from that word.
  - Store: write the word and set dirty.
  - Touch: the hit way's age becomes 0; ways younger than its old age increment by 1.
- Victim selection: lowest-index invalid way, else the way with age WAYS-1.
- State machine:
  - IDLE → WB on a request miss with a dirty victim.
  - IDLE → FILL on a request miss with a clean victim.
  - IDLE → SCAN on `halt` with no request. A request has priority over `halt`.
  - WB: write the victim's words 0..BLKWORDS-1 to {victim tag, idx, word, 2'b00}. Advance one word per transfer. After the last word, clear dirty and go to FILL.
  - FILL: read words 0..BLKWORDS-1 from {req tag, idx, word, 2'b00} into the victim. After the last word, set tag and valid, clear dirty, touch the way, return to IDLE. The request then hits combinationally.
  - SCAN: step a line pointer (set-major, way-minor) through all SETS×WAYS lines, one per cycle. A dirty valid line goes to FLUSH_WB. After the last line, go to HITCNT.
  - FLUSH_WB: write back the line as in WB, clear dirty, return to SCAN at the next line.
  - HITCNT: `dWEN`=1, `daddr`=HITCNT_ADDR, `dstore`=hit count. When the transfer completes, go to HALTED.
  - HALTED: `flushed`=1. Stay here until reset.
- Hit counter, 32 bits, wraps modulo 2^32:
  - Increments on each IDLE hit.
  - The replay hit that immediately follows a FILL is not counted; a one-bit replay flag, set at the end of FILL, marks it.
  - Misses do not change the counter.

## Timing
- Hit latency is 0 cycles: `dhit` is combinational from the request and the tag RAM.
- Array and LRU updates commit at the next CLK edge.
- Miss latency with zero `dwait` is 1 + (dirty ? BLKWORDS : 0) + BLKWORDS cycles until `dhit`.
- Each bus word holds `daddr`/`dstore` stable while `dwait`=1. Held `dwait` stalls indefinitely; no state advances.
- In IDLE, SCAN and HALTED, `dREN`=`dWEN`=0. `daddr`, `dstore` and `dmemload` are 0 whenever they are not in use.
- Reset values, applied asynchronously:
  - All valid, dirty and age bits = 0; hit counter = 0; state = IDLE; word and line pointers = 0.
  - All outputs = 0.
- Reset during WB, FILL or flush aborts the operation immediately. No partial line is left valid.
- Flush of a clean cache takes SETS×WAYS scan cycles, then the hit-count write.

## Structure
- Shared package `dcache_nway_pkg`:
  - Functions computing the field widths from the parameters.
  - Line record typedef (valid, dirty, tag, data array).
  - State enum: IDLE, WB, FILL, SCAN, FLUSH_WB, HITCNT, HALTED.
- Sub-module `lru_ages`, parametrised by WAYS:
  - Inputs: age vector, touched way.
  - Outputs: next age vector, victim way.
  - One instance per set, or one instance muxed on idx.

## Test plan
1. WAYS=2, SETS=8, BLKWORDS=2, memory zero-wait. Load 0x0000 (miss) then 0x0004 (hit) → 2 fill reads at 0x0000 and 0x0004; both loads return memory data; hit count = 1.
2. WAYS=4. Store 0xAAAA5555 to 0x0100. Then load four other tags mapping to the same set → dirty writeback of {0xAAAA5555, old word} to 0x0100 and 0x0104, occurring only on the 5th distinct tag.
3. LRU order: WAYS=4 set 0; fill ways A,B,C,D; touch A; miss → victim B.
4. `dwait` held high for 5 cycles during each FILL word → `daddr` stable for the whole stall; `dhit` arrives 10 cycles later than with zero wait.
5. Dirty lines in sets 1 and 6, then `halt` → writebacks in set order; then `dWEN` at 0x3100 with the hit count; then `flushed`=1 held.
6. Assert `nRST` mid-FILL → bus idle at once; the next access to that address misses.
